// File: rtl/fifo_wr_arbiter.sv
// ---------------------------------------------------------------------------
// fifo_wr_arbiter
//   Shares the write port of an async FIFO (w_clk domain) between NUM_REQ
//   requesters. A requester is granted a burst of up to MAX_BURST beats; the
//   burst ends early on the requester's last beat or if it withdraws its
//   request. The arbiter never writes while full_flag is set, so the FIFO is
//   never overwritten. There is one idle arbitration cycle between grants.
//
//   Configuration macro:
//     WR_ARB_FIXED_PRIO_EN  defined   -> lowest-index asserted request wins
//                           undefined -> round-robin starting after the
//                                        previous winner (default)
//
// Ports
//   w_clk      in   write-domain clock
//   w_rst_n    in   asynchronous active-low reset
//   req        in   per-requester write request (level)
//   req_last   in   per-requester "current beat is the last one"
//   req_data   in   packed write data, requester i at [i*DATA_WIDTH +: DATA_WIDTH]
//   full_flag  in   FIFO full, from the write-pointer block
//   ack        out  beat accepted this cycle (one-hot or zero)
//   w_inc      out  FIFO write enable
//   w_data     out  FIFO write data (zero when no grant is active)
//   grant_id   out  current / most recent granted requester
//   busy       out  a grant is active
// ---------------------------------------------------------------------------
module fifo_wr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 4
) (
  input  logic                          w_clk,
  input  logic                          w_rst_n,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ-1:0]            req_last,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic                          full_flag,
  output logic [NUM_REQ-1:0]            ack,
  output logic                          w_inc,
  output logic [DATA_WIDTH-1:0]         w_data,
  output logic [$clog2(NUM_REQ)-1:0]    grant_id,
  output logic                          busy
);

  localparam int IDW = $clog2(NUM_REQ);
  localparam int BCW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

  localparam logic [0:0]     S_IDLE    = 1'b0;
  localparam logic [0:0]     S_GRANT   = 1'b1;
  localparam logic [BCW-1:0] LAST_BEAT = BCW'(MAX_BURST - 1);

  logic [0:0]            state;
  logic [BCW-1:0]        beat_cnt;
  logic [IDW-1:0]        winner;
  logic                  req_g;
  logic                  last_g;
  logic [DATA_WIDTH-1:0] data_g;
  logic                  beat;
  logic                  release_g;

  // Pick out the granted requester's request, last flag and data.
  always_comb begin
    req_g  = 1'b0;
    last_g = 1'b0;
    data_g = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_id == IDW'(i)) begin
        req_g  = req[i];
        last_g = req_last[i];
        data_g = req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign busy   = (state == S_GRANT);
  assign beat   = busy & req_g & ~full_flag;
  assign w_inc  = beat;
  assign w_data = busy ? data_g : '0;

  always_comb begin
    ack = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      ack[i] = beat & (grant_id == IDW'(i));
    end
  end

  // A grant ends on the last beat, on the burst cap, or when the owner
  // drops its request. A full FIFO alone never ends a grant.
  assign release_g = busy & (~req_g | (beat & (last_g | (beat_cnt == LAST_BEAT))));

`ifdef WR_ARB_FIXED_PRIO_EN
  // Fixed priority: scanning downward leaves the lowest asserted index.
  always_comb begin
    winner = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req[i]) winner = IDW'(i);
    end
  end
`else
  logic [IDW-1:0] last_winner;
  logic [IDW-1:0] lo_win;
  logic [IDW-1:0] hi_win;
  logic           hi_found;

  // Round robin: prefer the lowest request above the previous winner,
  // otherwise wrap around to the lowest request overall.
  always_comb begin
    lo_win   = '0;
    hi_win   = '0;
    hi_found = 1'b0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req[i]) lo_win = IDW'(i);
      if (req[i] && (i > int'(last_winner))) begin
        hi_win   = IDW'(i);
        hi_found = 1'b1;
      end
    end
    winner = hi_found ? hi_win : lo_win;
  end

  // Reset value makes requester 0 the first in line.
  always_ff @(posedge w_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      last_winner <= IDW'(NUM_REQ - 1);
    end else if (release_g) begin
      last_winner <= grant_id;
    end
  end
`endif

  // Grant FSM: IDLE arbitrates and registers the winner, GRANT moves beats.
  always_ff @(posedge w_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      state    <= S_IDLE;
      grant_id <= '0;
      beat_cnt <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (|req) begin
            state    <= S_GRANT;
            grant_id <= winner;
            beat_cnt <= '0;
          end
        end
        default: begin
          if (release_g) begin
            state    <= S_IDLE;
            beat_cnt <= '0;
          end else if (beat) begin
            beat_cnt <= beat_cnt + BCW'(1);
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_fifo_wr_arbiter
//   Testbench for fifo_wr_arbiter. A directed reset sequence is followed by
//   randomized requesters that obey the request/ack handshake, random
//   full_flag, and a behavioural model of the grant rules predicting every
//   output each cycle.
// ---------------------------------------------------------------------------
module tb_fifo_wr_arbiter;

  localparam int NUM_REQ    = 4;
  localparam int DATA_WIDTH = 8;
  localparam int MAX_BURST  = 4;
  localparam int IDW        = $clog2(NUM_REQ);
  localparam int N_CYCLES   = 2000;

  logic                          w_clk = 1'b0;
  logic                          w_rst_n;
  logic [NUM_REQ-1:0]            req;
  logic [NUM_REQ-1:0]            req_last;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic                          full_flag;
  logic [NUM_REQ-1:0]            ack;
  logic                          w_inc;
  logic [DATA_WIDTH-1:0]         w_data;
  logic [IDW-1:0]                grant_id;
  logic                          busy;

  int total = 0;
  int bad   = 0;

  // Reference model state: who owns the port, beats so far, last winner.
  bit m_busy;
  int m_owner;
  int m_beats;
  int m_last;
  int m_gid;
  logic [NUM_REQ-1:0]    e_ack;
  logic [DATA_WIDTH-1:0] e_data;

  // Behavioural requesters.
  bit                    rq_active  [NUM_REQ];
  bit                    rq_started [NUM_REQ];
  int                    rq_left    [NUM_REQ];
  logic [DATA_WIDTH-1:0] rq_data    [NUM_REQ];

  fifo_wr_arbiter #(
    .NUM_REQ   (NUM_REQ),
    .DATA_WIDTH(DATA_WIDTH),
    .MAX_BURST (MAX_BURST)
  ) dut (
    .w_clk    (w_clk),
    .w_rst_n  (w_rst_n),
    .req      (req),
    .req_last (req_last),
    .req_data (req_data),
    .full_flag(full_flag),
    .ack      (ack),
    .w_inc    (w_inc),
    .w_data   (w_data),
    .grant_id (grant_id),
    .busy     (busy)
  );

  always #5 w_clk = ~w_clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic modelReset();
    m_busy  = 1'b0;
    m_owner = 0;
    m_beats = 0;
    m_last  = NUM_REQ - 1;
    m_gid   = 0;
    e_ack   = '0;
    e_data  = '0;
  endtask

  task automatic clearRequesters();
    for (int i = 0; i < NUM_REQ; i++) begin
      rq_active[i]  = 1'b0;
      rq_started[i] = 1'b0;
      rq_left[i]    = 0;
      rq_data[i]    = '0;
    end
    req       = '0;
    req_last  = '0;
    req_data  = '0;
    full_flag = 1'b0;
  endtask

  function automatic int pickWinner(input logic [NUM_REQ-1:0] r, input int lastw);
    int c;
`ifdef WR_ARB_FIXED_PRIO_EN
    c = lastw;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (r[i]) return i;
    end
`else
    for (int k = 1; k <= NUM_REQ; k++) begin
      c = (lastw + k) % NUM_REQ;
      if (r[c]) return c;
    end
`endif
    return -1;
  endfunction

  // Predict and compare this cycle's outputs from the current inputs.
  task automatic checkCycle();
    e_ack  = '0;
    e_data = '0;
    if (m_busy) begin
      e_data = req_data[m_owner*DATA_WIDTH +: DATA_WIDTH];
      if (req[m_owner] && !full_flag) e_ack[m_owner] = 1'b1;
    end
    checkOutput("busy",     32'(busy),     32'(m_busy));
    checkOutput("grant_id", 32'(grant_id), 32'(m_gid));
    checkOutput("ack",      32'(ack),      32'(e_ack));
    checkOutput("w_inc",    32'(w_inc),    32'(|e_ack));
    checkOutput("w_data",   32'(w_data),   32'(e_data));
  endtask

  // Advance the model across one clock edge.
  task automatic modelAdvance();
    int w;
    if (!m_busy) begin
      w = pickWinner(req, m_last);
      if (w >= 0) begin
        m_busy  = 1'b1;
        m_owner = w;
        m_gid   = w;
        m_beats = 0;
      end
    end else if (!req[m_owner]) begin
      m_busy = 1'b0;
      m_last = m_owner;
    end else if (!full_flag) begin
      m_beats++;
      if (req_last[m_owner] || m_beats == MAX_BURST) begin
        m_busy = 1'b0;
        m_last = m_owner;
      end
    end
  endtask

  // Requesters react to the beats accepted at the last edge and drive new inputs.
  task automatic applyStimulus();
    for (int i = 0; i < NUM_REQ; i++) begin
      if (e_ack[i]) begin
        rq_started[i] = 1'b1;
        rq_left[i]--;
        if (rq_left[i] == 0) rq_active[i] = 1'b0;
        else rq_data[i] = DATA_WIDTH'($urandom);
      end
      if (!rq_active[i]) begin
        if ($urandom_range(3) == 0) begin
          rq_active[i]  = 1'b1;
          rq_started[i] = 1'b0;
          rq_left[i]    = int'($urandom_range(6, 1));
          rq_data[i]    = DATA_WIDTH'($urandom);
        end
      end else if (!rq_started[i] && $urandom_range(15) == 0) begin
        rq_active[i] = 1'b0;
      end
      req[i]      = rq_active[i];
      req_last[i] = rq_active[i] && (rq_left[i] == 1);
      req_data[i*DATA_WIDTH +: DATA_WIDTH] = rq_active[i] ? rq_data[i] : DATA_WIDTH'($urandom);
    end
    full_flag = ($urandom_range(3) == 0);
  endtask

  initial begin
    // Directed: reset values, asynchronous reset in the middle of a grant.
    w_rst_n = 1'b0;
    clearRequesters();
    modelReset();
    repeat (2) @(posedge w_clk);
    #1 w_rst_n = 1'b1;
    @(negedge w_clk);
    checkOutput("rst_busy",  32'(busy),     32'd0);
    checkOutput("rst_grant", 32'(grant_id), 32'd0);
    checkOutput("rst_ack",   32'(ack),      32'd0);
    checkOutput("rst_winc",  32'(w_inc),    32'd0);

    req      = 4'b0001;
    req_last = 4'b0000;
    req_data = {8'h00, 8'h00, 8'h00, 8'hA5};
    @(posedge w_clk);
    #1;
    checkOutput("g0_busy",  32'(busy),     32'd1);
    checkOutput("g0_grant", 32'(grant_id), 32'd0);
    checkOutput("g0_winc",  32'(w_inc),    32'd1);
    checkOutput("g0_data",  32'(w_data),   32'hA5);

    #2 w_rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_ack",  32'(ack),      32'd0);
    checkOutput("mid_rst_winc", 32'(w_inc),    32'd0);
    checkOutput("mid_rst_busy", 32'(busy),     32'd0);
    checkOutput("mid_rst_gid",  32'(grant_id), 32'd0);
    checkOutput("mid_rst_data", 32'(w_data),   32'd0);

    req      = 4'b0100;
    req_last = 4'b0100;
    req_data = {8'h00, 8'h3C, 8'h00, 8'h00};
    @(negedge w_clk);
    w_rst_n = 1'b1;
    @(posedge w_clk);
    #1;
    checkOutput("post_rst_grant", 32'(grant_id), 32'd2);
    checkOutput("post_rst_busy",  32'(busy),     32'd1);
    checkOutput("post_rst_ack",   32'(ack),      32'b0100);
    checkOutput("post_rst_data",  32'(w_data),   32'h3C);

    // Randomized traffic against the reference model.
    @(negedge w_clk);
    w_rst_n = 1'b0;
    clearRequesters();
    modelReset();
    @(posedge w_clk);
    #1 w_rst_n = 1'b1;

    for (int cyc = 0; cyc < N_CYCLES; cyc++) begin
      @(negedge w_clk);
      checkCycle();
      if (cyc == N_CYCLES / 2) begin
        #1 w_rst_n = 1'b0;
        #1;
        checkOutput("rand_rst_busy", 32'(busy),  32'd0);
        checkOutput("rand_rst_ack",  32'(ack),   32'd0);
        checkOutput("rand_rst_winc", 32'(w_inc), 32'd0);
        clearRequesters();
        modelReset();
        @(posedge w_clk);
        #1 w_rst_n = 1'b1;
      end else begin
        @(posedge w_clk);
        modelAdvance();
        #1;
        applyStimulus();
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
